// File: rtl/ct_spsram_512x144_ctrl.sv
// rtl/ct_spsram_512x144_ctrl.sv - two-client round-robin controller for a 512x144 single-port SRAM
// Zero-fills the array after reset or init_req, then grants one client access per cycle.
module ct_spsram_512x144_ctrl #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 144
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  init_req,
    output logic                  init_done,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [DATA_WIDTH-1:0] req0_wmask,
    output logic                  req0_rdy,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [DATA_WIDTH-1:0] req1_wmask,
    output logic                  req1_rdy,
    output logic                  rd0_vld,
    output logic                  rd1_vld,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rr_q, rr_d;
    logic                  rd0_vld_q, rd0_vld_d;
    logic                  rd1_vld_q, rd1_vld_d;
    logic                  gnt0, gnt1;

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            rr_q      <= 1'b0;
            rd0_vld_q <= 1'b0;
            rd1_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rr_q      <= rr_d;
            rd0_vld_q <= rd0_vld_d;
            rd1_vld_q <= rd1_vld_d;
        end
    end

    // SRAM pins are combinational so a read granted in cycle N returns Q in N+1;
    // qualifying with cpurst_b keeps the macro idle while reset is held.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rr_d      = rr_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        init_done = 1'b0;
        sram_a    = '0;
        sram_cen  = 1'b1;
        sram_gwen = 1'b1;
        sram_wen  = '1;
        sram_d    = '0;
        if (cpurst_b) begin
            case (state_q)
                ST_INIT: begin
                    sram_cen  = 1'b0;
                    sram_gwen = 1'b0;
                    sram_wen  = '0;
                    sram_a    = cnt_q;
                    cnt_d     = cnt_q + 1'b1;
                    if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    init_done = 1'b1;
                    if (req0_vld && req1_vld) begin
                        gnt0 = ~rr_q;
                        gnt1 = rr_q;
                        rr_d = ~rr_q;
                    end else begin
                        gnt0 = req0_vld;
                        gnt1 = req1_vld;
                    end
                    if (gnt0) begin
                        sram_cen  = 1'b0;
                        sram_gwen = ~req0_wr;
                        sram_wen  = req0_wr ? ~req0_wmask : '1;
                        sram_d    = req0_wdata;
                        sram_a    = req0_addr;
                    end else if (gnt1) begin
                        sram_cen  = 1'b0;
                        sram_gwen = ~req1_wr;
                        sram_wen  = req1_wr ? ~req1_wmask : '1;
                        sram_d    = req1_wdata;
                        sram_a    = req1_addr;
                    end
                    if (init_req) begin
                        state_d = ST_INIT;
                        cnt_d   = '0;
                    end
                end
                default: state_d = ST_INIT;
            endcase
        end
    end

    assign rd0_vld_d = gnt0 & ~req0_wr;
    assign rd1_vld_d = gnt1 & ~req1_wr;

    assign req0_rdy = gnt0;
    assign req1_rdy = gnt1;
    assign rd0_vld  = rd0_vld_q;
    assign rd1_vld  = rd1_vld_q;
    assign rd_data  = sram_q;

endmodule

// File: tb/tb_ct_spsram_512x144_ctrl.sv
// tb/tb_ct_spsram_512x144_ctrl.sv - scoreboard bench for ct_spsram_512x144_ctrl with SRAM macro model
module tb_ct_spsram_512x144_ctrl;

    localparam int AW = 9;
    localparam int DW = 144;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          init_req;
    logic          init_done;
    logic          req0_vld, req0_wr, req0_rdy;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata, req0_wmask;
    logic          req1_vld, req1_wr, req1_rdy;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata, req1_wmask;
    logic          rd0_vld, rd1_vld;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] sram_a;
    logic          sram_cen, sram_gwen;
    logic [DW-1:0] sram_wen, sram_d, sram_q;

    always #5 clk = ~clk;

    ct_spsram_512x144_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .forever_cpuclk(clk),        .cpurst_b(rst_b),
        .init_req(init_req),         .init_done(init_done),
        .req0_vld(req0_vld),         .req0_wr(req0_wr),       .req0_addr(req0_addr),
        .req0_wdata(req0_wdata),     .req0_wmask(req0_wmask), .req0_rdy(req0_rdy),
        .req1_vld(req1_vld),         .req1_wr(req1_wr),       .req1_addr(req1_addr),
        .req1_wdata(req1_wdata),     .req1_wmask(req1_wmask), .req1_rdy(req1_rdy),
        .rd0_vld(rd0_vld),           .rd1_vld(rd1_vld),       .rd_data(rd_data),
        .sram_a(sram_a),             .sram_cen(sram_cen),     .sram_gwen(sram_gwen),
        .sram_wen(sram_wen),         .sram_d(sram_d),         .sram_q(sram_q)
    );

    // Single-port macro: active-low CEN/GWEN/bit-WEN, Q updated one cycle after a read.
    logic [DW-1:0] smem [512];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else            sram_q <= smem[sram_a];
        end
    end

    typedef struct {
        bit            cl;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    logic [DW-1:0] ref_mem [512];
    bit            m_init;
    int            m_iaddr;
    bit            m_rr;
    int            tests = 0;
    int            fails = 0;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [159:0] t;
        t = {$urandom, $urandom, $urandom, $urandom, $urandom};
        return t[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] rand_mask();
        case ($urandom % 4)
            0:       return '0;
            1:       return '1;
            default: return rand_data();
        endcase
    endfunction

    task automatic model_reset();
        m_init  = 1'b1;
        m_iaddr = 0;
        m_rr    = 1'b0;
        for (int i = 0; i < 512; i++) ref_mem[i] = '0;
    endtask

    task automatic check_reset_vals();
        chk("rst_init_done", init_done, 0);
        chk("rst_rdy0", req0_rdy, 0);
        chk("rst_rdy1", req1_rdy, 0);
        chk("rst_rd0_vld", rd0_vld, 0);
        chk("rst_rd1_vld", rd1_vld, 0);
        chk("rst_cen", sram_cen, 1);
        chk("rst_gwen", sram_gwen, 1);
        chk("rst_wen", sram_wen, '1);
        chk("rst_a", sram_a, 0);
        chk("rst_d", sram_d, 0);
    endtask

    // Reference behaviour for one cycle, evaluated mid-cycle while inputs are stable.
    task automatic model_cycle();
        int            g;
        bit            w;
        int            a;
        logic [DW-1:0] d, m;
        if (m_init) begin
            chk("init_done_low", init_done, 0);
            chk("init_rdy0", req0_rdy, 0);
            chk("init_rdy1", req1_rdy, 0);
            chk("init_cen", sram_cen, 0);
            chk("init_gwen", sram_gwen, 0);
            chk("init_wen", sram_wen, '0);
            chk("init_d", sram_d, '0);
            chk("init_a", sram_a, m_iaddr);
            m_iaddr++;
            if (m_iaddr == 512) begin
                m_init  = 1'b0;
                m_iaddr = 0;
            end
            return;
        end
        chk("run_init_done", init_done, 1);
        g = -1;
        if (req0_vld && req1_vld) begin
            g    = m_rr ? 1 : 0;
            m_rr = ~m_rr;
        end else if (req0_vld) g = 0;
        else if (req1_vld)     g = 1;
        chk("rdy0", req0_rdy, (g == 0));
        chk("rdy1", req1_rdy, (g == 1));
        if (g < 0) begin
            chk("idle_cen", sram_cen, 1);
            chk("idle_gwen", sram_gwen, 1);
            chk("idle_wen", sram_wen, '1);
        end else begin
            w = (g == 0) ? req0_wr : req1_wr;
            a = (g == 0) ? int'(req0_addr) : int'(req1_addr);
            d = (g == 0) ? req0_wdata : req1_wdata;
            m = (g == 0) ? req0_wmask : req1_wmask;
            chk("acc_cen", sram_cen, 0);
            chk("acc_a", sram_a, a);
            if (w) begin
                chk("wr_gwen", sram_gwen, 0);
                chk("wr_wen", sram_wen, ~m);
                chk("wr_d", sram_d, d);
                for (int b = 0; b < DW; b++) if (m[b]) ref_mem[a][b] = d[b];
            end else begin
                chk("rd_gwen", sram_gwen, 1);
                chk("rd_wen", sram_wen, '1);
                rq.push_back('{cl: (g == 1), data: ref_mem[a]});
            end
        end
        if (init_req) begin
            m_init  = 1'b1;
            m_iaddr = 0;
            for (int i = 0; i < 512; i++) ref_mem[i] = '0;
        end
    endtask

    // Read-return monitor: every read handshake must come back exactly one cycle later.
    initial begin
        rd_t e;
        forever begin
            @(posedge clk);
            #3;
            if (rq.size() > 0) begin
                e = rq.pop_front();
                chk("rd0_vld", rd0_vld, (e.cl == 1'b0));
                chk("rd1_vld", rd1_vld, (e.cl == 1'b1));
                chk("rd_data", rd_data, e.data);
            end else begin
                chk("rd0_vld_idle", rd0_vld, 0);
                chk("rd1_vld_idle", rd1_vld, 0);
            end
        end
    end

    task automatic set_req(input bit c, input bit v, input bit w, input int a,
                           input logic [DW-1:0] d, input logic [DW-1:0] m);
        if (!c) begin
            req0_vld = v; req0_wr = w; req0_addr = AW'(a); req0_wdata = d; req0_wmask = m;
        end else begin
            req1_vld = v; req1_wr = w; req1_addr = AW'(a); req1_wdata = d; req1_wmask = m;
        end
    endtask

    task automatic idle_reqs();
        set_req(0, 0, 0, 0, '0, '0);
        set_req(1, 0, 0, 0, '0, '0);
    endtask

    task automatic rand_reqs();
        for (int c = 0; c < 2; c++) begin
            set_req(c[0], ($urandom % 4) != 0, $urandom % 2,
                    ($urandom % 2) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, 511)),
                    rand_data(), rand_mask());
        end
    endtask

    task automatic step();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
        init_req = 1'b0;
    endtask

    task automatic pulse_reset();
        rq.delete();
        rst_b = 1'b0;
        @(negedge clk);
        check_reset_vals();
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        model_reset();
    endtask

    initial begin
        rst_b    = 1'b0;
        init_req = 1'b0;
        idle_reqs();
        repeat (3) @(posedge clk);
        #1;
        pulse_reset();

        repeat (512) begin
            rand_reqs();
            init_req = ($urandom % 50) == 0;
            step();
        end

        set_req(0, 1, 0, 5, '0, '0);
        set_req(1, 1, 0, 6, '0, '0);
        repeat (4) step();

        idle_reqs();
        set_req(0, 1, 1, 10, '1, {{(DW-16){1'b0}}, 16'hFFFF});
        step();
        set_req(0, 1, 0, 10, '0, '0);
        step();

        idle_reqs();
        set_req(1, 1, 1, 511, rand_data(), '1);
        step();
        set_req(1, 0, 0, 0, '0, '0);
        set_req(0, 1, 0, 511, '0, '0);
        step();

        set_req(0, 1, 1, 3, {16'hA5C3, {(DW-16){1'b1}}}, '1);
        step();
        set_req(0, 1, 0, 3, '0, '0);
        init_req = 1'b1;
        step();
        repeat (512) begin
            rand_reqs();
            step();
        end
        idle_reqs();
        set_req(0, 1, 0, 3, '0, '0);
        step();

        idle_reqs();
        init_req = 1'b1;
        step();
        while (m_iaddr != 200) begin
            rand_reqs();
            step();
        end
        pulse_reset();
        repeat (513) begin
            rand_reqs();
            step();
        end

        repeat (3000) begin
            rand_reqs();
            init_req = ($urandom % 1000) == 0;
            step();
        end

        idle_reqs();
        repeat (2) step();
        chk("rq_drained", rq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
